grant_toggle_gen: RTL and testbench

- Stimulus-side generator for the req/grant handshake checked by the team's toggle-count assertion benches.
- On a start pulse it raises req, then changes grant a fixed number of times, with each change separated by a programmable number of cycles.
- It drops req in the cycle immediately after the final grant change.
- It sits directly upstream of the req/grant property checker and drives both checked signals, so the protocol is produced by RTL rather than hand-timed initial blocks.

---
 rtl/grant_toggle_gen_if.sv | 47 ++++
 rtl/grant_toggle_gen.sv | 148 ++++++++++++++
 tb/tb_grant_toggle_gen.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/grant_toggle_gen_if.sv
// Handshake bundle between the grant/req generator and whatever starts and observes it.
interface grant_toggle_gen_if #(
  parameter int unsigned GAP_W = 4
);

  localparam int unsigned CNT_W = 4;

  // Control into the generator
  logic             start;
  logic [GAP_W-1:0] gap;
  logic             abort;

  // Protocol lines and status out of the generator
  logic             req;
  logic             grant;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] toggle_cnt;

  // Generator side
  modport master (
    input  start,
    input  gap,
    input  abort,
    output req,
    output grant,
    output busy,
    output done,
    output aborted,
    output toggle_cnt
  );

  // Controller / observer side
  modport slave (
    output start,
    output gap,
    output abort,
    input  req,
    input  grant,
    input  busy,
    input  done,
    input  aborted,
    input  toggle_cnt
  );

endinterface

// File: rtl/grant_toggle_gen.sv
// Drives a req/grant transaction: raise req, toggle grant NUM_TOGGLES times
// spaced by a clamped programmable gap, then drop req one cycle after the last toggle.
module grant_toggle_gen #(
  parameter int unsigned NUM_TOGGLES = 3,
  parameter int unsigned GAP_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  grant_toggle_gen_if.master    bus
);

  localparam int unsigned CNT_W = 4;

  // Index of the final change; toggle_cnt equals this just before the last toggle.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TOGGLES - 1);
  // Smallest effective gap; keeps grant changes on non-consecutive cycles.
  localparam logic [GAP_W-1:0] MIN_GAP  = GAP_W'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic             grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] rld_q, rld_d;

  logic [GAP_W-1:0] gap_eff_c;
  logic [GAP_W-1:0] gap_rld_c;
  logic             cnt_zero_c;
  logic             last_c;

  // Clamp the requested gap and derive the counter reload value g-1.
  always_comb begin
    gap_eff_c  = (bus.gap < MIN_GAP) ? MIN_GAP : bus.gap;
    gap_rld_c  = gap_eff_c - GAP_W'(1);
    cnt_zero_c = (cnt_q == '0);
    last_c     = (tcnt_q == LAST_IDX);
  end

  // State and output registers; async reset clears everything including grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      grant_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      tcnt_q    <= '0;
      cnt_q     <= '0;
      rld_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      tcnt_q    <= tcnt_d;
      cnt_q     <= cnt_d;
      rld_q     <= rld_d;
    end
  end

  // Next-state: abort beats a coincident toggle; DROP always lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (cnt_zero_c && last_c) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next values for the registered outputs and the gap counter.
  always_comb begin
    req_d     = req_q;
    grant_d   = grant_q;
    tcnt_d    = tcnt_q;
    cnt_d     = cnt_q;
    rld_d     = rld_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    busy_d    = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          req_d  = 1'b1;
          tcnt_d = '0;
          cnt_d  = gap_rld_c;
          rld_d  = gap_rld_c;
        end
      end
      S_WAIT: begin
        if (bus.abort) begin
          req_d     = 1'b0;
          aborted_d = 1'b1;
        end else if (!cnt_zero_c) begin
          cnt_d = cnt_q - GAP_W'(1);
        end else begin
          grant_d = ~grant_q;
          tcnt_d  = tcnt_q + CNT_W'(1);
          if (!last_c) begin
            cnt_d = rld_q;
          end
        end
      end
      S_DROP: begin
        req_d  = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  assign bus.req        = req_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
  assign bus.toggle_cnt = tcnt_q;

endmodule

// File: tb/tb_grant_toggle_gen.sv
// Directed bench for grant_toggle_gen: timing of req/grant/done/aborted per scenario.
module tb_grant_toggle_gen;

  localparam int unsigned NUM_TOGGLES = 3;
  localparam int unsigned GAP_W       = 4;

  logic clk = 1'b0;
  logic rst;

  int tests = 0;
  int fails = 0;

  // Bench-side record of the grant level at the start of the next transaction.
  logic model_grant;

  grant_toggle_gen_if #(.GAP_W(GAP_W)) bus ();

  grant_toggle_gen #(
    .NUM_TOGGLES (NUM_TOGGLES),
    .GAP_W       (GAP_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Sample point: 1 ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed outputs packed as {req, busy, done, aborted, grant, toggle_cnt}.
  function automatic logic [8:0] obs_vec();
    return {bus.req, bus.busy, bus.done, bus.aborted, bus.grant, bus.toggle_cnt};
  endfunction

  task automatic test_reset();
    logic [8:0] obs;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.gap   = '0;
    bus.abort = 1'b0;
    model_grant = 1'b0;
    tick();
    tick();
    obs = obs_vec();
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL reset_hold got %b exp %b", obs, 9'b0);
    end
    bus.start = 1'b1;
    tick();
    obs = obs_vec();
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL reset_start_ignored got %b exp %b", obs, 9'b0);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
    obs = obs_vec();
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL idle_hold got %b exp %b", obs, 9'b0);
    end
  endtask

  // One complete transaction: start with gapv, expect changes every g edges.
  task automatic run_txn(input logic [GAP_W-1:0] gapv, input int g, input string name);
    logic [8:0] obs;
    logic [8:0] exp;
    int         ch;
    int         n;
    n = int'(NUM_TOGGLES);
    bus.start = 1'b1;
    bus.gap   = gapv;
    tick();
    bus.start = 1'b0;
    bus.gap   = 4'hF;
    for (int k = 0; k <= n * g; k++) begin
      if (k != 0) tick();
      ch  = k / g;
      exp = {1'b1, 1'b1, 1'b0, 1'b0, model_grant ^ ch[0], 4'(ch)};
      obs = obs_vec();
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL %s k=%0d got %b exp %b", name, k, obs, exp);
      end
    end
    tick();
    exp = {1'b0, 1'b0, 1'b1, 1'b0, model_grant ^ n[0], 4'(n)};
    obs = obs_vec();
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s done_edge got %b exp %b", name, obs, exp);
    end
    tick();
    exp = {1'b0, 1'b0, 1'b0, 1'b0, model_grant ^ n[0], 4'(n)};
    obs = obs_vec();
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s after_done got %b exp %b", name, obs, exp);
    end
    model_grant = model_grant ^ n[0];
  endtask

  task automatic test_gap2();
    tick();
    run_txn(4'd2, 2, "gap2");
  endtask

  task automatic test_gap5();
    run_txn(4'd5, 5, "gap5");
  endtask

  task automatic test_clamp();
    run_txn(4'd0, 2, "gap0");
    run_txn(4'd1, 2, "gap1");
  endtask

  task automatic test_back_to_back();
    logic [8:0] obs;
    logic [8:0] exp [0:8];
    logic       m;
    int         ch;
    m = model_grant;
    exp[0] = {1'b1, 1'b1, 1'b0, 1'b0,  m, 4'd0};
    exp[1] = {1'b1, 1'b1, 1'b0, 1'b0,  m, 4'd0};
    exp[2] = {1'b1, 1'b1, 1'b0, 1'b0, ~m, 4'd1};
    exp[3] = {1'b1, 1'b1, 1'b0, 1'b0, ~m, 4'd1};
    exp[4] = {1'b1, 1'b1, 1'b0, 1'b0,  m, 4'd2};
    exp[5] = {1'b1, 1'b1, 1'b0, 1'b0,  m, 4'd2};
    exp[6] = {1'b1, 1'b1, 1'b0, 1'b0, ~m, 4'd3};
    exp[7] = {1'b0, 1'b0, 1'b1, 1'b0, ~m, 4'd3};
    exp[8] = {1'b1, 1'b1, 1'b0, 1'b0, ~m, 4'd0};
    bus.start = 1'b1;
    bus.gap   = 4'd2;
    for (int k = 0; k <= 8; k++) begin
      // Busy-time start at edge 3 and DROP-edge start at edge 7 must be ignored;
      // start held into edge 8 is accepted with the gap present then.
      bus.start = (k == 0) || (k == 3) || (k == 7) || (k == 8);
      bus.gap   = (k == 3) ? 4'd7 : (k >= 7) ? 4'd3 : 4'd2;
      tick();
      obs = obs_vec();
      tests++;
      if (obs !== exp[k]) begin
        fails++;
        $display("FAIL b2b k=%0d got %b exp %b", k, obs, exp[k]);
      end
    end
    bus.start = 1'b0;
    m = ~m;
    for (int j = 1; j <= 10; j++) begin
      tick();
      ch = j / 3;
      if (j == 10) begin
        exp[0] = {1'b0, 1'b0, 1'b1, 1'b0, ~m, 4'd3};
      end else begin
        exp[0] = {1'b1, 1'b1, 1'b0, 1'b0, m ^ ch[0], 4'(ch)};
      end
      obs = obs_vec();
      tests++;
      if (obs !== exp[0]) begin
        fails++;
        $display("FAIL b2b_second j=%0d got %b exp %b", j, obs, exp[0]);
      end
    end
    model_grant = ~m;
  endtask

  task automatic test_abort();
    logic [8:0] obs;
    logic [8:0] exp;
    logic       m;
    m = model_grant;
    bus.start = 1'b1;
    bus.gap   = 4'd3;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = (k >= 3) ? {1'b1, 1'b1, 1'b0, 1'b0, ~m, 4'd1}
                     : {1'b1, 1'b1, 1'b0, 1'b0,  m, 4'd0};
      obs = obs_vec();
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL abort_pre k=%0d got %b exp %b", k, obs, exp);
      end
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    exp = {1'b0, 1'b0, 1'b0, 1'b1, ~m, 4'd1};
    obs = obs_vec();
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL abort_edge got %b exp %b", obs, exp);
    end
    exp = {1'b0, 1'b0, 1'b0, 1'b0, ~m, 4'd1};
    for (int k = 0; k < 8; k++) begin
      bus.abort = (k == 4);
      tick();
      obs = obs_vec();
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL abort_post k=%0d got %b exp %b", k, obs, exp);
      end
    end
    bus.abort = 1'b0;
    model_grant = ~m;
  endtask

  task automatic test_async_reset();
    logic [8:0] obs;
    bus.start = 1'b1;
    bus.gap   = 4'd4;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    obs = obs_vec();
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL async_reset got %b exp %b", obs, 9'b0);
    end
    #3;
    rst = 1'b0;
    model_grant = 1'b0;
    tick();
    obs = obs_vec();
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL post_reset_idle got %b exp %b", obs, 9'b0);
    end
    run_txn(4'd2, 2, "post_reset");
  endtask

  initial begin
    test_reset();
    test_gap2();
    test_gap5();
    test_clamp();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
